// File: rtl/softplus_fwd_pipe.sv
// SoftPlus y = ln(1+e^x) on a Q8.8 stream: 3-stage pipeline with a 16-segment LUT and linear interpolation.
// Optional macro SOFTPLUS_GRAD_OUT_EN adds out_grad, the per-sample slope aligned with out_data.
module softplus_fwd_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef SOFTPLUS_GRAD_OUT_EN
    ,
    output logic [15:0]      out_grad
`endif
);

    localparam int STAGES = 3;

    typedef enum logic [1:0] {
        CLS_MID = 2'd0,
        CLS_HI  = 2'd1,
        CLS_LO  = 2'd2
    } cls_t;

    typedef struct packed {
        cls_t             cls;
        logic [3:0]       seg;
        logic [7:0]       frac;
        logic [15:0]      x;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        cls_t             cls;
        logic [15:0]      base;
        logic [16:0]      prod;
        logic [15:0]      x;
        logic [TAG_W-1:0] tag;
`ifdef SOFTPLUS_GRAD_OUT_EN
        logic [8:0]       slope;
`endif
    } s2_t;

    // Index is the 4-bit two's-complement integer part k; entries 8..15 hold k = -8..-1.
    function automatic logic [15:0] base_lut(input logic [3:0] seg);
        logic [15:0] b;
        case (seg)
            4'd0:  b = 16'd177;
            4'd1:  b = 16'd336;
            4'd2:  b = 16'd544;
            4'd3:  b = 16'd780;
            4'd4:  b = 16'd1029;
            4'd5:  b = 16'd1282;
            4'd6:  b = 16'd1537;
            4'd7:  b = 16'd1792;
            4'd8:  b = 16'd0;
            4'd9:  b = 16'd0;
            4'd10: b = 16'd1;
            4'd11: b = 16'd2;
            4'd12: b = 16'd5;
            4'd13: b = 16'd12;
            4'd14: b = 16'd32;
            default: b = 16'd80;
        endcase
        return b;
    endfunction

    function automatic logic [8:0] slope_lut(input logic [3:0] seg);
        logic [8:0] s;
        case (seg)
            4'd0:  s = 9'd159;
            4'd1:  s = 9'd208;
            4'd2:  s = 9'd236;
            4'd3:  s = 9'd248;
            4'd4:  s = 9'd253;
            4'd5:  s = 9'd255;
            4'd6:  s = 9'd256;
            4'd7:  s = 9'd256;
            4'd8:  s = 9'd0;
            4'd9:  s = 9'd0;
            4'd10: s = 9'd1;
            4'd11: s = 9'd3;
            4'd12: s = 9'd8;
            4'd13: s = 9'd20;
            4'd14: s = 9'd48;
            default: s = 9'd97;
        endcase
        return s;
    endfunction

    logic [STAGES:1] vld_pipe;
    logic            adv;
    s1_t             s1, s1_d;
    s2_t             s2, s2_d;
    logic [8:0]      slope_v;
    logic [15:0]     y_d;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    // S1: classify into saturated tails or an interpolated segment
    always_comb begin
        s1_d      = '0;
        s1_d.x    = in_data;
        s1_d.tag  = in_tag;
        s1_d.seg  = in_data[11:8];
        s1_d.frac = in_data[7:0];
        if ($signed(in_data) >= 16'sd2048)
            s1_d.cls = CLS_HI;
        else if ($signed(in_data) < -16'sd2048)
            s1_d.cls = CLS_LO;
        else
            s1_d.cls = CLS_MID;
    end

    // S2: LUT lookup and slope*frac product
    always_comb begin
        slope_v   = slope_lut(s1.seg);
        s2_d      = '0;
        s2_d.cls  = s1.cls;
        s2_d.base = base_lut(s1.seg);
        s2_d.prod = 17'(slope_v) * 17'(s1.frac);
        s2_d.x    = s1.x;
        s2_d.tag  = s1.tag;
`ifdef SOFTPLUS_GRAD_OUT_EN
        s2_d.slope = slope_v;
`endif
    end

    // S3: base*256 + prod then >>8 equals base + truncated (prod >> 8)
    always_comb begin
        case (s2.cls)
            CLS_HI:  y_d = s2.x;
            CLS_LO:  y_d = 16'h0000;
            default: y_d = 16'(({8'b0, s2.base, 8'b0} + {15'b0, s2.prod}) >> 8);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
            out_data <= '0;
            out_tag  <= '0;
`ifdef SOFTPLUS_GRAD_OUT_EN
            out_grad <= '0;
`endif
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1       <= s1_d;
            s2       <= s2_d;
            if (vld_pipe[STAGES-1]) begin
                out_data <= y_d;
                out_tag  <= s2.tag;
`ifdef SOFTPLUS_GRAD_OUT_EN
                case (s2.cls)
                    CLS_HI:  out_grad <= 16'h0100;
                    CLS_LO:  out_grad <= 16'h0000;
                    default: out_grad <= {7'b0, s2.slope};
                endcase
`endif
            end
        end
    end

endmodule

// File: tb/tb_softplus_fwd_pipe.sv
// Self-checking bench for softplus_fwd_pipe: real-math reference model + scoreboard, plus literal vectors.
module tb_softplus_fwd_pipe;
    localparam int TAG_W = 4;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             in_valid = 0;
    logic             in_ready;
    logic [15:0]      in_data = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef SOFTPLUS_GRAD_OUT_EN
    logic [15:0]      out_grad;
`endif

    softplus_fwd_pipe #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef SOFTPLUS_GRAD_OUT_EN
        , .out_grad(out_grad)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int n_out = 0;
    int last_stall = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: softplus sampled at integers, rounded half-up, then linearly interpolated.
    function automatic real sp(input real v);
        return $ln(1.0 + $exp(v));
    endfunction

    function automatic int rnd(input real v);
        return int'($floor(v + 0.5));
    endfunction

    function automatic int seg_of(input int xs);
        return int'($floor(real'(xs) / 256.0));
    endfunction

    function automatic logic [15:0] model_y(input logic [15:0] x);
        int xs, k, fr, b, s;
        xs = int'($signed(x));
        if (xs >= 2048) return x;
        if (xs < -2048) return 16'h0000;
        k  = seg_of(xs);
        fr = xs - 256 * k;
        b  = rnd(256.0 * sp(real'(k)));
        s  = rnd(256.0 * (sp(real'(k + 1)) - sp(real'(k))));
        return 16'(b + (s * fr) / 256);
    endfunction

    function automatic logic [15:0] model_g(input logic [15:0] x);
        int xs, k;
        xs = int'($signed(x));
        if (xs >= 2048) return 16'h0100;
        if (xs < -2048) return 16'h0000;
        k = seg_of(xs);
        return 16'(rnd(256.0 * (sp(real'(k + 1)) - sp(real'(k)))));
    endfunction

    typedef struct {
        logic [15:0]      d;
        logic [TAG_W-1:0] t;
        logic [15:0]      g;
        int               acc;
    } exp_t;

    exp_t q[$];
    logic             stall_prev = 0;
    logic [15:0]      held_d;
    logic [TAG_W-1:0] held_t;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: transfers are judged at the negedge preceding the edge that performs them.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            stall_prev = 0;
        end else begin
            chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (stall_prev) begin
                chk("hold_data", {16'b0, out_data}, {16'b0, held_d});
                chk("hold_tag", {28'b0, out_tag}, {28'b0, held_t});
            end
            stall_prev = out_valid && !out_ready;
            held_d = out_data;
            held_t = out_tag;
            if (out_valid && !out_ready) last_stall = cyc;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", {16'b0, out_data}, {16'b0, e.d});
                    chk("sb_tag", {28'b0, out_tag}, {28'b0, e.t});
                    chk("sb_sign", {31'b0, out_data[15]}, 32'd0);
`ifdef SOFTPLUS_GRAD_OUT_EN
                    chk("sb_grad", {16'b0, out_grad}, {16'b0, e.g});
`endif
                    if (e.acc > last_stall) chk("sb_latency", 32'(cyc - e.acc), 32'd3);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                e.d = model_y(in_data);
                e.t = in_tag;
                e.g = model_g(in_data);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    logic [TAG_W-1:0] tagc = '0;
    logic [15:0]      last_g = '0;

    // Single isolated sample; also checks the literal expectation and the 3-cycle latency.
    task automatic one(input logic [15:0] x, input logic [15:0] exp_y);
        int n;
        in_valid = 1; in_data = x; in_tag = tagc; tagc++;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("lat_%h", x), 32'(n + 1), 32'd3);
        chk($sformatf("lit_%h", x), {16'b0, out_data}, {16'b0, exp_y});
`ifdef SOFTPLUS_GRAD_OUT_EN
        last_g = out_grad;
`endif
        @(posedge clk); #1;
    endtask

    logic [15:0] bp_x [8] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0700,
                              16'h0800, 16'hF7FF, 16'h0080, 16'h0340};

    initial begin
        int idx, base_out;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_out_tag", {28'b0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // Model pinned against hand-derived results as well as DUT literals.
        chk("model_pin_0", {16'b0, model_y(16'h0000)}, 32'h00B1);
        chk("model_pin_m05", {16'b0, model_y(16'hFF80)}, 32'h0080);

        one(16'h0000, 16'h00B1);
        one(16'h0100, 16'h0150);
        one(16'hFF00, 16'h0050);
        one(16'h0700, 16'h0700);
        one(16'h0800, 16'h0800);
        one(16'h1234, 16'h1234);
        one(16'hF7FF, 16'h0000);
        one(16'hF800, 16'h0000);
        one(16'h7FFF, 16'h7FFF);
        one(16'h8000, 16'h0000);
        one(16'h0080, 16'h0100);
        one(16'hFF80, 16'h0080);
        one(16'h0780, 16'h0780);
        one(16'hF880, 16'h0000);
`ifdef SOFTPLUS_GRAD_OUT_EN
        one(16'h0000, 16'h00B1);
        chk("grad_0", {16'b0, last_g}, 32'h009F);
        one(16'h0900, 16'h0900);
        chk("grad_hi", {16'b0, last_g}, 32'h0100);
        one(16'h8000, 16'h0000);
        chk("grad_lo", {16'b0, last_g}, 32'h0000);
`endif

        // Backpressure: 8 samples, out_ready low in cycles 4..6.
        idx = 0;
        base_out = n_out;
        for (int c = 0; c < 24; c++) begin
            out_ready = !(c >= 4 && c <= 6);
            in_valid = (idx < 8);
            in_data = bp_x[idx & 7];
            in_tag = TAG_W'(idx);
            @(negedge clk);
            if (c >= 4 && c <= 6) chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 0; out_ready = 1;
        chk("bp_count", 32'(n_out - base_out), 32'd8);

        // Back-to-back random stream.
        base_out = n_out;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1;
            in_data = i[0] ? 16'($urandom) : 16'($urandom_range(0, 4351)) - 16'd2176;
            in_tag = TAG_W'(i);
            @(negedge clk);
            if (!in_ready) chk("rand_in_ready", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("rand_count", 32'(n_out - base_out), 32'd256);

        // Reset mid-stream: flight is dropped, outputs clear at once.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = 16'h0100 * 16'(i); in_tag = TAG_W'(i);
            @(posedge clk); #1;
        end
        rst_n = 0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {16'b0, out_data}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid) chk("post_rst_no_output", 32'd1, 32'd0);
        end
        chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
